// File: rtl/axi4_mmio_responder.sv
// axi4_mmio_responder
// AXI4 subordinate that terminates a 64-bit MMIO master port with a small
// byte-strobed scratchpad behind a fixed address window. The read and write
// paths are independent state machines. Each path has at most one
// transaction in flight.

module axi4_mmio_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
    parameter int          DEPTH_WORDS = 16
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    // write address channel
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [3:0]  S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWQOS,
    // write data channel
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    // write response channel
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    output logic [3:0]  S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    // read address channel
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    input  logic [3:0]  S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARQOS,
    // read data channel
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [3:0]  S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_MASK = ~(32'(DEPTH_WORDS * 8) - 32'd1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rState_t;

    // The response class is fixed when the address is accepted.
    // A decode miss takes priority over an unsupported size or burst type.
    function automatic logic [1:0] classify(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
        logic [1:0] cls;
        cls = RESP_OKAY;
        if ((addr & WIN_MASK) != BASE_ADDR) begin
            cls = RESP_DECERR;
        end else if (size > 3'd3 || burst[1]) begin
            cls = RESP_SLVERR;
        end
        return cls;
    endfunction

    // INCR advances by the beat size with a plain 32-bit wrap.
    // FIXED (and the error bursts) keep the address unchanged.
    function automatic logic [31:0] advance(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
        logic [31:0] nxt;
        nxt = addr;
        if (burst == BURST_INCR) begin
            nxt = addr + (32'd1 << size);
        end
        return nxt;
    endfunction

    logic [63:0] mem_q [DEPTH_WORDS];

    wState_t     wState_q;
    logic        awReady_q, wReady_q, bValid_q;
    logic [3:0]  bId_q;
    logic [1:0]  bResp_q;
    logic [31:0] wrAddr_q;
    logic [7:0]  wrLen_q;
    logic [2:0]  wrSize_q;
    logic [1:0]  wrBurst_q;
    logic [1:0]  wrClass_q;
    logic [8:0]  wrBeat_q;

    rState_t     rState_q;
    logic        arReady_q, rValid_q, rLast_q;
    logic [3:0]  rId_q;
    logic [1:0]  rResp_q;
    logic [63:0] rData_q;
    logic [31:0] rdAddr_q;
    logic [7:0]  rdLen_q;
    logic [2:0]  rdSize_q;
    logic [1:0]  rdBurst_q;
    logic [1:0]  rdClass_q;
    logic [7:0]  rdBeat_q;

    logic [31:0] wrAddr_d, rdAddr_d;
    logic [1:0]  awClass_d, arClass_d;
    logic        wFire_d, memWrEn_d;
    logic        unusedIgnored;

    assign awClass_d = classify(S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST);
    assign arClass_d = classify(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
    assign wrAddr_d  = advance(wrAddr_q, wrSize_q, wrBurst_q);
    assign rdAddr_d  = advance(rdAddr_q, rdSize_q, rdBurst_q);

    // Storage is only touched on an OKAY-class burst and never past LEN.
    assign wFire_d   = wReady_q && S_AXI_WVALID;
    assign memWrEn_d = wFire_d && (wrClass_q == RESP_OKAY) &&
                       (wrBeat_q <= {1'b0, wrLen_q});

    assign unusedIgnored = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                             BURST_FIXED};

    // Scratchpad storage with a byte-strobed write port, cleared on reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWrEn_d) begin
            for (int b = 0; b < 8; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem_q[wrAddr_q[3 +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Write path: accept the address, then consume data beats until WLAST,
    // then hold the B response until the master takes it.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wState_q  <= W_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bId_q     <= '0;
            bResp_q   <= RESP_OKAY;
            wrAddr_q  <= '0;
            wrLen_q   <= '0;
            wrSize_q  <= '0;
            wrBurst_q <= '0;
            wrClass_q <= RESP_OKAY;
            wrBeat_q  <= '0;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    awReady_q <= 1'b1;
                    if (awReady_q && S_AXI_AWVALID) begin
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b1;
                        bId_q     <= S_AXI_AWID;
                        wrAddr_q  <= S_AXI_AWADDR;
                        wrLen_q   <= S_AXI_AWLEN;
                        wrSize_q  <= S_AXI_AWSIZE;
                        wrBurst_q <= S_AXI_AWBURST;
                        wrClass_q <= awClass_d;
                        wrBeat_q  <= '0;
                        wState_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wFire_d) begin
                        wrAddr_q <= wrAddr_d;
                        if (wrBeat_q != 9'h1FF) begin
                            wrBeat_q <= wrBeat_q + 9'd1;
                        end
                        if (S_AXI_WLAST) begin
                            wReady_q <= 1'b0;
                            bValid_q <= 1'b1;
                            if (wrClass_q != RESP_OKAY) begin
                                bResp_q <= wrClass_q;
                            end else if (wrBeat_q != {1'b0, wrLen_q}) begin
                                bResp_q <= RESP_SLVERR;
                            end else begin
                                bResp_q <= RESP_OKAY;
                            end
                            wState_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bValid_q  <= 1'b0;
                        awReady_q <= 1'b1;
                        wState_q  <= W_IDLE;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Read path: accept the address with beat 0 already registered, then
    // present one beat per RREADY cycle, loading the next word on each handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rState_q  <= R_IDLE;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            rId_q     <= '0;
            rResp_q   <= RESP_OKAY;
            rData_q   <= '0;
            rdAddr_q  <= '0;
            rdLen_q   <= '0;
            rdSize_q  <= '0;
            rdBurst_q <= '0;
            rdClass_q <= RESP_OKAY;
            rdBeat_q  <= '0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    arReady_q <= 1'b1;
                    if (arReady_q && S_AXI_ARVALID) begin
                        arReady_q <= 1'b0;
                        rValid_q  <= 1'b1;
                        rId_q     <= S_AXI_ARID;
                        rResp_q   <= arClass_d;
                        rdAddr_q  <= S_AXI_ARADDR;
                        rdLen_q   <= S_AXI_ARLEN;
                        rdSize_q  <= S_AXI_ARSIZE;
                        rdBurst_q <= S_AXI_ARBURST;
                        rdClass_q <= arClass_d;
                        rdBeat_q  <= '0;
                        rLast_q   <= (S_AXI_ARLEN == 8'd0);
                        rData_q   <= (arClass_d == RESP_OKAY) ?
                                     mem_q[S_AXI_ARADDR[3 +: IDX_W]] : '0;
                        rState_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rLast_q) begin
                            rValid_q  <= 1'b0;
                            rLast_q   <= 1'b0;
                            arReady_q <= 1'b1;
                            rState_q  <= R_IDLE;
                        end else begin
                            rdAddr_q <= rdAddr_d;
                            rdBeat_q <= rdBeat_q + 8'd1;
                            rLast_q  <= ((rdBeat_q + 8'd1) == rdLen_q);
                            rData_q  <= (rdClass_q == RESP_OKAY) ?
                                        mem_q[rdAddr_d[3 +: IDX_W]] : '0;
                        end
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awReady_q;
    assign S_AXI_WREADY  = wReady_q;
    assign S_AXI_BVALID  = bValid_q;
    assign S_AXI_BID     = bId_q;
    assign S_AXI_BRESP   = bResp_q;
    assign S_AXI_ARREADY = arReady_q;
    assign S_AXI_RVALID  = rValid_q;
    assign S_AXI_RID     = rId_q;
    assign S_AXI_RDATA   = rData_q;
    assign S_AXI_RRESP   = rResp_q;
    assign S_AXI_RLAST   = rLast_q;

endmodule

// File: tb/tb_axi4_mmio_responder.sv
// tb_axi4_mmio_responder
// Directed bench for the MMIO responder: a table of single transactions
// plus hand-written burst, stall, concurrency and reset sequences.

module tb_axi4_mmio_responder;

    logic        clk;
    logic        rstN;
    logic        awValid, awReady;
    logic [3:0]  awId;
    logic [31:0] awAddr;
    logic [7:0]  awLen;
    logic [2:0]  awSize;
    logic [1:0]  awBurst;
    logic        wValid, wReady;
    logic [63:0] wData;
    logic [7:0]  wStrb;
    logic        wLast;
    logic        bValid, bReady;
    logic [3:0]  bId;
    logic [1:0]  bResp;
    logic        arValid, arReady;
    logic [3:0]  arId;
    logic [31:0] arAddr;
    logic [7:0]  arLen;
    logic [2:0]  arSize;
    logic [1:0]  arBurst;
    logic        rValid, rReady;
    logic [3:0]  rId;
    logic [63:0] rData;
    logic [1:0]  rResp;
    logic        rLast;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  expResp;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs [16];

    axi4_mmio_responder #(
        .BASE_ADDR  (32'h6000_0000),
        .DEPTH_WORDS(16)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstN),
        .S_AXI_AWVALID(awValid),
        .S_AXI_AWREADY(awReady),
        .S_AXI_AWID   (awId),
        .S_AXI_AWADDR (awAddr),
        .S_AXI_AWLEN  (awLen),
        .S_AXI_AWSIZE (awSize),
        .S_AXI_AWBURST(awBurst),
        .S_AXI_AWLOCK (1'b0),
        .S_AXI_AWCACHE(4'h0),
        .S_AXI_AWPROT (3'h0),
        .S_AXI_AWQOS  (4'h0),
        .S_AXI_WVALID (wValid),
        .S_AXI_WREADY (wReady),
        .S_AXI_WDATA  (wData),
        .S_AXI_WSTRB  (wStrb),
        .S_AXI_WLAST  (wLast),
        .S_AXI_BVALID (bValid),
        .S_AXI_BREADY (bReady),
        .S_AXI_BID    (bId),
        .S_AXI_BRESP  (bResp),
        .S_AXI_ARVALID(arValid),
        .S_AXI_ARREADY(arReady),
        .S_AXI_ARID   (arId),
        .S_AXI_ARADDR (arAddr),
        .S_AXI_ARLEN  (arLen),
        .S_AXI_ARSIZE (arSize),
        .S_AXI_ARBURST(arBurst),
        .S_AXI_ARLOCK (1'b0),
        .S_AXI_ARCACHE(4'h0),
        .S_AXI_ARPROT (3'h0),
        .S_AXI_ARQOS  (4'h0),
        .S_AXI_RVALID (rValid),
        .S_AXI_RREADY (rReady),
        .S_AXI_RID    (rId),
        .S_AXI_RDATA  (rData),
        .S_AXI_RRESP  (rResp),
        .S_AXI_RLAST  (rLast)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some sequence stalls beyond its own bounds.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Full write transaction. BREADY is held off for one cycle to confirm B holds.
    task automatic doWrite(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] id, input int nBeats,
                           input logic [63:0] dBase, input logic [7:0] strb,
                           input logic [1:0] expResp);
        int guard;
        awValid = 1'b1; awAddr = addr; awLen = len; awSize = size;
        awBurst = burst; awId = id;
        guard = 0;
        while (!awReady && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        checkOutput("awready", {63'd0, awReady}, 64'd1);
        @(posedge clk); @(negedge clk);
        awValid = 1'b0;
        checkOutput("wready latency", {63'd0, wReady}, 64'd1);
        for (int i = 0; i < nBeats; i++) begin
            wValid = 1'b1;
            wData  = dBase + 64'(i);
            wStrb  = strb;
            wLast  = (i == nBeats - 1);
            guard  = 0;
            while (!wReady && guard < 50) begin
                @(posedge clk); @(negedge clk); guard++;
            end
            if (!wReady) checkOutput("wready wait", {63'd0, wReady}, 64'd1);
            @(posedge clk); @(negedge clk);
        end
        wValid = 1'b0; wLast = 1'b0;
        checkOutput("bvalid latency", {63'd0, bValid}, 64'd1);
        checkOutput("bresp", {62'd0, bResp}, {62'd0, expResp});
        checkOutput("bid", {60'd0, bId}, {60'd0, id});
        @(posedge clk); @(negedge clk);
        checkOutput("bvalid held", {63'd0, bValid}, 64'd1);
        checkOutput("bresp held", {62'd0, bResp}, {62'd0, expResp});
        bReady = 1'b1;
        @(posedge clk); @(negedge clk);
        bReady = 1'b0;
        checkOutput("bvalid drop", {63'd0, bValid}, 64'd0);
        checkOutput("awready after b", {63'd0, awReady}, 64'd1);
    endtask

    // Full read transaction; beat n is expected to be exp0 + n*step.
    // With stall set, RREADY alternates 1,0,1,0 starting with 1.
    task automatic doRead(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] id, input logic [1:0] expResp,
                          input logic [63:0] exp0, input logic [63:0] step,
                          input logic stall);
        int guard;
        int beat;
        int cyc;
        arValid = 1'b1; arAddr = addr; arLen = len; arSize = size;
        arBurst = burst; arId = id;
        guard = 0;
        while (!arReady && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        checkOutput("arready", {63'd0, arReady}, 64'd1);
        @(posedge clk); @(negedge clk);
        arValid = 1'b0;
        checkOutput("rvalid latency", {63'd0, rValid}, 64'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 600) begin
            checkOutput("rvalid", {63'd0, rValid}, 64'd1);
            checkOutput("rdata", rData, exp0 + 64'(beat) * step);
            checkOutput("rresp", {62'd0, rResp}, {62'd0, expResp});
            checkOutput("rlast", {63'd0, rLast}, {63'd0, beat == int'(len)});
            checkOutput("rid", {60'd0, rId}, {60'd0, id});
            rReady = stall ? (cyc % 2 == 0) : 1'b1;
            @(posedge clk); @(negedge clk);
            if (rReady) beat++;
            cyc++;
        end
        rReady = 1'b0;
        if (beat <= int'(len)) checkOutput("read beats", 64'(beat), 64'(len) + 64'd1);
        checkOutput("rvalid drop", {63'd0, rValid}, 64'd0);
        checkOutput("arready after r", {63'd0, arReady}, 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input logic [3:0] id);
        if (v.isWrite) begin
            doWrite(v.addr, v.len, v.size, v.burst, id, int'(v.len) + 1,
                    v.data, v.strb, v.expResp);
        end else begin
            doRead(v.addr, v.len, v.size, v.burst, id, v.expResp,
                   v.expData, 64'd0, 1'b0);
        end
    endtask

    initial begin
        // isWrite, addr, len, size, burst, data, strb, expResp, expData
        vecs[0]  = '{1'b1, 32'h6000_0008, 8'd0, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 2'b00, 64'd0};
        vecs[1]  = '{1'b0, 32'h6000_0008, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'h1122334455667788};
        vecs[2]  = '{1'b0, 32'h7000_0000, 8'd1, 3'd3, 2'b01, 64'd0, 8'h00, 2'b11, 64'd0};
        vecs[3]  = '{1'b1, 32'h7000_0000, 8'd0, 3'd3, 2'b01, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'b11, 64'd0};
        vecs[4]  = '{1'b0, 32'h6000_0000, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'd0};
        vecs[5]  = '{1'b1, 32'h6000_0010, 8'd0, 3'd3, 2'b10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b10, 64'd0};
        vecs[6]  = '{1'b0, 32'h6000_0010, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'd2};
        vecs[7]  = '{1'b0, 32'h6000_0008, 8'd0, 3'd4, 2'b01, 64'd0, 8'h00, 2'b10, 64'd0};
        vecs[8]  = '{1'b1, 32'h6000_0018, 8'd0, 3'd3, 2'b11, 64'h7777777777777777, 8'hFF, 2'b10, 64'd0};
        vecs[9]  = '{1'b1, 32'h6000_0020, 8'd0, 3'd2, 2'b01, 64'hCAFEBABE12345678, 8'hF0, 2'b00, 64'd0};
        vecs[10] = '{1'b0, 32'h6000_0020, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'hCAFEBABE00000000};
        vecs[11] = '{1'b1, 32'h6000_0078, 8'd0, 3'd3, 2'b01, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 64'd0};
        vecs[12] = '{1'b0, 32'h6000_0078, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'h0123456789ABCDEF};
        vecs[13] = '{1'b0, 32'h6000_0080, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b11, 64'd0};
        vecs[14] = '{1'b0, 32'h5FFF_FFF8, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b11, 64'd0};
        vecs[15] = '{1'b0, 32'h6000_0018, 8'd0, 3'd3, 2'b01, 64'd0, 8'h00, 2'b00, 64'd3};

        rstN = 1'b0;
        awValid = 1'b0; awId = '0; awAddr = '0; awLen = '0; awSize = '0; awBurst = '0;
        wValid = 1'b0; wData = '0; wStrb = '0; wLast = 1'b0; bReady = 1'b0;
        arValid = 1'b0; arId = '0; arAddr = '0; arLen = '0; arSize = '0; arBurst = '0;
        rReady = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset awready", {63'd0, awReady}, 64'd0);
        checkOutput("reset arready", {63'd0, arReady}, 64'd0);
        checkOutput("reset wready", {63'd0, wReady}, 64'd0);
        checkOutput("reset bvalid", {63'd0, bValid}, 64'd0);
        checkOutput("reset rvalid", {63'd0, rValid}, 64'd0);
        checkOutput("reset rdata", rData, 64'd0);
        checkOutput("reset rlast", {63'd0, rLast}, 64'd0);
        checkOutput("reset resp", {60'd0, bResp, rResp}, 64'd0);
        rstN = 1'b1;
        #1;
        checkOutput("arready before edge", {63'd0, arReady}, 64'd0);
        @(posedge clk); @(negedge clk);
        checkOutput("awready after reset", {63'd0, awReady}, 64'd1);
        checkOutput("arready after reset", {63'd0, arReady}, 64'd1);

        // Strobed INCR burst, then read back with RREADY toggling.
        doWrite(32'h6000_0000, 8'd3, 3'd3, 2'b01, 4'd1, 4,
                64'hAAAA_AAAA_0000_0000, 8'h0F, 2'b00);
        doRead(32'h6000_0000, 8'd3, 3'd3, 2'b01, 4'd2, 2'b00, 64'd0, 64'd1, 1'b1);

        // FIXED burst: both beats hit the same word, the last one wins.
        doWrite(32'h6000_0028, 8'd1, 3'd3, 2'b00, 4'd3, 2,
                64'h5555_0000_0000_0010, 8'hFF, 2'b00);
        doRead(32'h6000_0028, 8'd1, 3'd3, 2'b00, 4'd4, 2'b00,
               64'h5555_0000_0000_0011, 64'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], 4'(i));
        end

        // WLAST arrives one beat early: LEN=3 but only three beats.
        doWrite(32'h6000_0030, 8'd3, 3'd3, 2'b01, 4'd5, 3,
                64'h0000_0000_0000_0100, 8'hFF, 2'b10);

        // Same-cycle read and write of word 2: the read sees the old value.
        doWrite(32'h6000_0010, 8'd0, 3'd3, 2'b01, 4'd6, 1,
                64'h0101_0101_0101_0101, 8'hFF, 2'b00);
        awValid = 1'b1; awAddr = 32'h6000_0010; awLen = 8'd0; awSize = 3'd3;
        awBurst = 2'b01; awId = 4'd7;
        arValid = 1'b1; arAddr = 32'h6000_0008; arLen = 8'd1; arSize = 3'd3;
        arBurst = 2'b01; arId = 4'd8;
        checkOutput("conc awready", {63'd0, awReady}, 64'd1);
        checkOutput("conc arready", {63'd0, arReady}, 64'd1);
        @(posedge clk); @(negedge clk);
        awValid = 1'b0; arValid = 1'b0;
        checkOutput("conc wready", {63'd0, wReady}, 64'd1);
        checkOutput("conc rvalid", {63'd0, rValid}, 64'd1);
        checkOutput("conc beat0", rData, 64'h1122334455667788);
        wValid = 1'b1; wData = 64'h0202_0202_0202_0202; wStrb = 8'hFF; wLast = 1'b1;
        rReady = 1'b1;
        @(posedge clk); @(negedge clk);
        wValid = 1'b0; wLast = 1'b0;
        checkOutput("conc beat1 old", rData, 64'h0101_0101_0101_0101);
        checkOutput("conc rlast", {63'd0, rLast}, 64'd1);
        checkOutput("conc bvalid", {63'd0, bValid}, 64'd1);
        checkOutput("conc bresp", {62'd0, bResp}, 64'd0);
        bReady = 1'b1;
        @(posedge clk); @(negedge clk);
        bReady = 1'b0; rReady = 1'b0;
        checkOutput("conc b done", {63'd0, bValid}, 64'd0);
        checkOutput("conc r done", {63'd0, rValid}, 64'd0);
        doRead(32'h6000_0010, 8'd0, 3'd3, 2'b01, 4'd9, 2'b00,
               64'h0202_0202_0202_0202, 64'd0, 1'b0);

        // Reset in the middle of a read burst.
        arValid = 1'b1; arAddr = 32'h6000_0000; arLen = 8'd3; arSize = 3'd3;
        arBurst = 2'b01; arId = 4'd10;
        checkOutput("mid arready", {63'd0, arReady}, 64'd1);
        @(posedge clk); @(negedge clk);
        arValid = 1'b0;
        rReady = 1'b1;
        @(posedge clk); @(negedge clk);
        rReady = 1'b0;
        checkOutput("mid rvalid", {63'd0, rValid}, 64'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort rvalid", {63'd0, rValid}, 64'd0);
        checkOutput("abort arready", {63'd0, arReady}, 64'd0);
        checkOutput("abort rdata", rData, 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("release arready", {63'd0, arReady}, 64'd0);
        @(posedge clk); @(negedge clk);
        checkOutput("rearm arready", {63'd0, arReady}, 64'd1);
        checkOutput("rearm awready", {63'd0, awReady}, 64'd1);
        doRead(32'h6000_0010, 8'd0, 3'd3, 2'b01, 4'd11, 2'b00, 64'd0, 64'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
